// File: rtl/mul_accumulator.sv
// Accumulates BLOCK_LEN multiplier products (one per rising edge of prod_ack)
// and offers each block sum on a valid/ready port; a sum dropped while the port is full sets overrun.
module mul_accumulator #(
  parameter int PROD_W    = 16,
  parameter int BLOCK_LEN = 4,
  parameter int ACC_W     = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_ack,
  input  logic              clr,
  output logic [ACC_W-1:0]  sum_out,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [7:0]        count,
  output logic              overrun,
  output logic [ACC_W-1:0]  acc
);

  // Handshake: sum_out is transferred at a rising edge where sum_valid and
  // sum_ready are both 1. sum_valid is a pure register output, so it never
  // depends combinationally on sum_ready, and sum_out is frozen while it is 1.

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  localparam logic [7:0] LAST = 8'(BLOCK_LEN - 1);

  out_state_t       out_state;
  logic             ack_q;
  logic             capture;
  logic             accept;
  logic [ACC_W-1:0] prod_ext;

  assign prod_ext  = ACC_W'(prod);
  assign capture   = prod_ack && !ack_q;
  assign accept    = (out_state == FULL) && sum_ready;
  assign sum_valid = (out_state == FULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_state <= EMPTY;
      ack_q     <= 1'b0;
      acc       <= '0;
      count     <= '0;
      sum_out   <= '0;
      overrun   <= 1'b0;
    end else if (clr) begin
      // sum_out deliberately keeps its last value across a clear
      out_state <= EMPTY;
      ack_q     <= 1'b0;
      acc       <= '0;
      count     <= '0;
      overrun   <= 1'b0;
    end else begin
      ack_q <= prod_ack;
      if (accept) begin
        out_state <= EMPTY;
      end
      if (capture) begin
        if (count == LAST) begin
          acc   <= '0;
          count <= '0;
          // A completed sum is kept if the slot is empty or is emptying this edge
          if (out_state == EMPTY || accept) begin
            sum_out   <= acc + prod_ext;
            out_state <= FULL;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          acc   <= acc + prod_ext;
          count <= count + 8'd1;
        end
      end
    end
  end

endmodule
